// File: rtl/seq_key_ctrl_pkg.sv
// Shared types and defaults for the key-to-bit sequencer.
// Imported by the edge detector and the controller top.
package seq_key_ctrl_pkg;

    localparam int GAP_CYCLES_DEF = 16;
    localparam int HIST_W_DEF     = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_CLEAR = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

endpackage

// File: rtl/seq_key_ctrl_rise_det.sv
// Single-bit rising-edge detector with a registered edge pulse.
// The previous-level flop resets to 1 so a key held through reset is ignored.
module rise_det
    import seq_key_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic lvl_i,
    output logic rise_o
);

    logic prev_q;
    logic rise_q;

    // Track the previous level every cycle and register the edge pulse
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            prev_q <= 1'b1;
            rise_q <= 1'b0;
        end else begin
            prev_q <= lvl_i;
            rise_q <= lvl_i & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/seq_key_ctrl.sv
// Turns debounced 0/1/clear key presses into single-bit transfers
// toward a sequence detector, with release hold-off and a quiet gap.
module seq_key_ctrl
    import seq_key_ctrl_pkg::*;
#(
    parameter int GAP_CYCLES = GAP_CYCLES_DEF,
    parameter int HIST_W     = HIST_W_DEF,
    localparam int CNT_W     = $clog2(HIST_W + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              db_0,
    input  logic              db_1,
    input  logic              db_clr,
    input  logic              det_rdy,
    output logic              bit_out,
    output logic              bit_vld,
    output logic              clr_pls,
    output logic              err,
    output logic [HIST_W-1:0] hist,
    output logic [CNT_W-1:0]  cnt,
    output logic              busy
);

    localparam logic [15:0]      GAP_LAST = 16'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(HIST_W);

    logic              r0;
    logic              r1;
    logic              rclr;
    logic              any_lvl;

    state_e            state_q;
    logic              bit_out_q;
    logic              bit_vld_q;
    logic              clr_pls_q;
    logic              err_q;
    logic [HIST_W-1:0] hist_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [15:0]       gap_q;

    rise_det u_rise_0 (
        .clk    (clk),
        .rst_n  (rst_n),
        .lvl_i  (db_0),
        .rise_o (r0)
    );

    rise_det u_rise_1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .lvl_i  (db_1),
        .rise_o (r1)
    );

    rise_det u_rise_clr (
        .clk    (clk),
        .rst_n  (rst_n),
        .lvl_i  (db_clr),
        .rise_o (rclr)
    );

    assign any_lvl = db_0 | db_1 | db_clr;

    // Control FSM with registered outputs; edges are only honoured in IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            bit_out_q <= 1'b0;
            bit_vld_q <= 1'b0;
            clr_pls_q <= 1'b0;
            err_q     <= 1'b0;
            hist_q    <= '0;
            cnt_q     <= '0;
            gap_q     <= '0;
        end else begin
            err_q     <= 1'b0;
            clr_pls_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (rclr) begin
                        clr_pls_q <= 1'b1;
                        state_q   <= ST_CLEAR;
                    end else if (r0 && r1) begin
                        err_q   <= 1'b1;
                        state_q <= ST_HOLD;
                    end else if (r0 || r1) begin
                        bit_out_q <= r1;
                        bit_vld_q <= 1'b1;
                        state_q   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (det_rdy) begin
                        hist_q    <= {hist_q[HIST_W-2:0], bit_out_q};
                        bit_vld_q <= 1'b0;
                        state_q   <= ST_HOLD;
                        if (cnt_q != CNT_MAX) begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                ST_CLEAR: begin
                    hist_q  <= '0;
                    cnt_q   <= '0;
                    state_q <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!any_lvl) begin
                        gap_q   <= '0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (any_lvl) begin
                        gap_q   <= '0;
                        state_q <= ST_HOLD;
                    end else if (gap_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 16'd1;
                    end
                end
                default: begin
                    bit_vld_q <= 1'b0;
                    state_q   <= ST_IDLE;
                end
            endcase
        end
    end

    assign bit_out = bit_out_q;
    assign bit_vld = bit_vld_q;
    assign clr_pls = clr_pls_q;
    assign err     = err_q;
    assign hist    = hist_q;
    assign cnt     = cnt_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_seq_key_ctrl.sv
// Directed bench for seq_key_ctrl: table of key entries plus
// hand-written sequences for stalls, collisions, clear and reset.
module tb_seq_key_ctrl;

    localparam int GAP = 4;
    localparam int HW  = 8;
    localparam int CW  = $clog2(HW + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          db_0, db_1, db_clr, det_rdy;
    logic          bit_out, bit_vld, clr_pls, err, busy;
    logic [HW-1:0] hist;
    logic [CW-1:0] cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int vld_seen;

    typedef struct {
        logic          key;
        logic [HW-1:0] exp_hist;
        logic [CW-1:0] exp_cnt;
    } vec_t;

    vec_t tbl [9];

    seq_key_ctrl #(.GAP_CYCLES(GAP), .HIST_W(HW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .db_0    (db_0),
        .db_1    (db_1),
        .db_clr  (db_clr),
        .det_rdy (det_rdy),
        .bit_out (bit_out),
        .bit_vld (bit_vld),
        .clr_pls (clr_pls),
        .err     (err),
        .hist    (hist),
        .cnt     (cnt),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_idle(input string nm);
        int k;
        vld_seen = 0;
        for (k = 0; k < 60; k++) begin
            if (!busy) break;
            if (bit_vld) vld_seen++;
            tick();
        end
        chk({nm, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic press(input logic key, input string nm);
        if (key) db_1 = 1'b1;
        else     db_0 = 1'b1;
        tick();
        chk({nm, "_early"}, {31'd0, bit_vld}, 32'd0);
        tick();
        chk({nm, "_vld"}, {31'd0, bit_vld}, 32'd1);
        chk({nm, "_bit"}, {31'd0, bit_out}, {31'd0, key});
        tick();
        chk({nm, "_drop"}, {31'd0, bit_vld}, 32'd0);
        db_0 = 1'b0;
        db_1 = 1'b0;
        wait_idle(nm);
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h01, 4'd1};
        tbl[1] = '{1'b0, 8'h02, 4'd2};
        tbl[2] = '{1'b1, 8'h05, 4'd3};
        tbl[3] = '{1'b1, 8'h0B, 4'd4};
        tbl[4] = '{1'b0, 8'h16, 4'd5};
        tbl[5] = '{1'b0, 8'h2C, 4'd6};
        tbl[6] = '{1'b1, 8'h59, 4'd7};
        tbl[7] = '{1'b1, 8'hB3, 4'd8};
        tbl[8] = '{1'b1, 8'h67, 4'd8};

        rst_n = 1'b0; db_0 = 1'b0; db_1 = 1'b0;
        db_clr = 1'b0; det_rdy = 1'b1;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        chk("rst_vld",  {31'd0, bit_vld}, 32'd0);
        chk("rst_out",  {31'd0, bit_out}, 32'd0);
        chk("rst_clr",  {31'd0, clr_pls}, 32'd0);
        chk("rst_err",  {31'd0, err},     32'd0);
        chk("rst_hist", {24'd0, hist},    32'd0);
        chk("rst_cnt",  {28'd0, cnt},     32'd0);
        chk("rst_busy", {31'd0, busy},    32'd0);

        // single db_1 entry, with exact gap length
        db_1 = 1'b1;
        tick();
        chk("b1_early", {31'd0, bit_vld}, 32'd0);
        tick();
        chk("b1_vld", {31'd0, bit_vld}, 32'd1);
        chk("b1_bit", {31'd0, bit_out}, 32'd1);
        chk("b1_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("b1_drop", {31'd0, bit_vld}, 32'd0);
        chk("b1_hist", {24'd0, hist}, 32'h01);
        chk("b1_cnt",  {28'd0, cnt},  32'd1);
        db_1 = 1'b0;
        repeat (4) tick();
        chk("gap_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("gap_done", {31'd0, busy}, 32'd0);

        // stalled transfer
        det_rdy = 1'b0;
        db_0 = 1'b1;
        tick();
        tick();
        chk("st_vld", {31'd0, bit_vld}, 32'd1);
        chk("st_bit", {31'd0, bit_out}, 32'd0);
        db_0 = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("st_hold_vld", {31'd0, bit_vld}, 32'd1);
            chk("st_hold_bit", {31'd0, bit_out}, 32'd0);
            chk("st_hold_hist", {24'd0, hist}, 32'h01);
        end
        det_rdy = 1'b1;
        tick();
        chk("st_drop", {31'd0, bit_vld}, 32'd0);
        chk("st_hist", {24'd0, hist}, 32'h02);
        chk("st_cnt",  {28'd0, cnt},  32'd2);
        wait_idle("st");

        // simultaneous 0 and 1
        db_0 = 1'b1;
        db_1 = 1'b1;
        tick();
        chk("cx_err0", {31'd0, err}, 32'd0);
        tick();
        chk("cx_err", {31'd0, err}, 32'd1);
        chk("cx_vld", {31'd0, bit_vld}, 32'd0);
        tick();
        chk("cx_err_end", {31'd0, err}, 32'd0);
        db_0 = 1'b0;
        db_1 = 1'b0;
        wait_idle("cx");
        chk("cx_novld", vld_seen, 32'd0);
        chk("cx_hist", {24'd0, hist}, 32'h02);
        chk("cx_cnt",  {28'd0, cnt},  32'd2);

        // third entry, then clear together with db_1
        press(1'b1, "e3");
        chk("e3_hist", {24'd0, hist}, 32'h05);
        chk("e3_cnt",  {28'd0, cnt},  32'd3);
        db_clr = 1'b1;
        db_1 = 1'b1;
        tick();
        tick();
        chk("cl_pls", {31'd0, clr_pls}, 32'd1);
        chk("cl_vld", {31'd0, bit_vld}, 32'd0);
        tick();
        chk("cl_pls_end", {31'd0, clr_pls}, 32'd0);
        chk("cl_hist", {24'd0, hist}, 32'd0);
        chk("cl_cnt",  {28'd0, cnt},  32'd0);
        db_clr = 1'b0;
        db_1 = 1'b0;
        wait_idle("cl");
        chk("cl_novld", vld_seen, 32'd0);

        // table of nine entries from a cleared history
        for (int i = 0; i < 9; i++) begin
            press(tbl[i].key, "tbl");
            chk("tbl_hist", {24'd0, hist}, {24'd0, tbl[i].exp_hist});
            chk("tbl_cnt",  {28'd0, cnt},  {28'd0, tbl[i].exp_cnt});
        end

        // key held through reset release
        db_1 = 1'b1;
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        vld_seen = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bit_vld || busy) vld_seen++;
        end
        chk("hr_quiet", vld_seen, 32'd0);
        chk("hr_hist", {24'd0, hist}, 32'd0);
        db_1 = 1'b0;
        repeat (2) tick();
        db_1 = 1'b1;
        tick();
        tick();
        chk("hr_vld", {31'd0, bit_vld}, 32'd1);
        tick();
        chk("hr_hist1", {24'd0, hist}, 32'h01);
        db_1 = 1'b0;
        tick();
        tick();
        db_1 = 1'b1;
        vld_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bit_vld) vld_seen++;
            chk("hr_gap_busy", {31'd0, busy}, 32'd1);
        end
        chk("hr_gap_novld", vld_seen, 32'd0);
        db_1 = 1'b0;
        wait_idle("hr");
        chk("hr_gap_novld2", vld_seen, 32'd0);
        chk("hr_hist2", {24'd0, hist}, 32'h01);
        chk("hr_cnt2",  {28'd0, cnt},  32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/seq_key_ctrl.md
SEQ_KEY_CTRL -- requirements
Module: seq_key_ctrl

Interface
REQ-001 Parameter GAP_CYCLES, default 16: idle cycles enforced after all keys are released before the next key is accepted; valid range 1..65535.
REQ-002 Parameter HIST_W, default 8: width of the entered-bit history register and saturation limit of cnt.
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst_n  input  1  reset, synchronous and active-low.
REQ-005 db_0  input  1  debounced level of the "enter 0" key, synchronous to clk.
REQ-006 db_1  input  1  debounced level of the "enter 1" key, synchronous to clk.
REQ-007 db_clr  input  1  debounced level of the "clear" key, synchronous to clk.
REQ-008 det_rdy  input  1  sequence detector ready to accept a bit.
REQ-009 bit_out  output  1  bit offered to the detector.
REQ-010 bit_vld  output  1  bit_out valid; transfer occurs when bit_vld and det_rdy are both 1 at posedge clk.
REQ-011 clr_pls  output  1  one-cycle pulse commanding a detector clear.
REQ-012 err  output  1  one-cycle pulse when db_0 and db_1 rise in the same cycle.
REQ-013 hist  output  HIST_W  last accepted bits, newest in bit 0.
REQ-014 cnt  output  $clog2(HIST_W+1)  number of accepted bits since clear, saturating at HIST_W.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-016 Rising edge per key = current level AND NOT a registered previous level; the previous-level registers update every cycle in every state.
REQ-017 FSM states are IDLE, ISSUE, CLEAR, HOLD and GAP, and no others; unreachable encodings go to IDLE.
REQ-018 IDLE with a db_clr rise goes to CLEAR; clear has priority over db_0 and db_1 edges in the same cycle.
REQ-019 IDLE with exactly one of db_0 or db_1 rising goes to ISSUE and latches bit_out (0 for db_0, 1 for db_1).
REQ-020 IDLE with db_0 and db_1 rising together (no clr rise) pulses err for one cycle, goes to HOLD and issues no bit.
REQ-021 ISSUE holds bit_vld=1 and a stable bit_out until det_rdy=1, with no timeout.
REQ-022 On the ISSUE transfer cycle: hist <= {hist[HIST_W-2:0], bit_out}; cnt increments unless cnt==HIST_W; FSM goes to HOLD.
REQ-023 bit_vld drops in the cycle after transfer.
REQ-024 CLEAR lasts exactly one cycle: clr_pls=1, hist <= 0, cnt <= 0, then HOLD.
REQ-025 HOLD waits until db_0, db_1 and db_clr are all 0, then goes to GAP with the gap counter loaded to 0.
REQ-026 GAP counts cycles and goes to IDLE after GAP_CYCLES cycles.
REQ-027 Any key level going high during GAP reloads the counter to 0 and returns the FSM to HOLD.
REQ-028 Key edges occurring outside IDLE are discarded and never queued.
REQ-029 Latency: a key first sampled high at edge k gives bit_vld=1 (or clr_pls=1) after edge k+1, i.e. one cycle.
REQ-030 bit_vld, clr_pls and err are mutually exclusive in any cycle.
REQ-031 busy is 0 exactly when the state is IDLE.

Reset
REQ-032 While rst_n=0 at posedge clk, the FSM goes to IDLE and bit_out, bit_vld, clr_pls, err, hist, cnt and the gap counter all go to 0.
REQ-033 While rst_n=0, the previous-level registers load 1, so a key held through reset release produces no edge until it is released and pressed again.
REQ-034 Reset asserted during ISSUE drops bit_vld on the next edge, performs no hist update and sends no transfer.

Structure
REQ-035 A shared package holds the FSM state enum and the localparam defaults for GAP_CYCLES and HIST_W.
REQ-036 One sub-module, rise_det (single-bit rising-edge detector with previous-level register reset to 1), is instantiated three times.
REQ-037 The block contains no debounce logic; its inputs come from the existing debounce stage.

Verification
REQ-038 Reset, then db_1 pulse with det_rdy=1 -> bit_vld one cycle with bit_out=1; hist=0x01, cnt=1.
REQ-039 det_rdy held 0 for 10 cycles after a db_0 press -> bit_vld and bit_out=0 held stable for 10 cycles; transfer on the cycle det_rdy rises; hist unchanged until then.
REQ-040 db_0 and db_1 rise in the same cycle -> err pulse, no bit_vld, hist and cnt unchanged.
REQ-041 Keys 1,0,1,1,0,0,1,1,1 entered with GAP_CYCLES=4 -> hist=0x67 (HIST_W=8), cnt=8 saturated.
REQ-042 db_clr and db_1 rise together after 3 entries -> clr_pls one cycle, hist=0, cnt=0, no bit_vld.
REQ-043 db_1 held high through reset release -> no bit_vld until db_1 falls and rises again; a second press inside GAP restarts HOLD and issues no bit.
